// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared constants and types for the CACHE write-port
//                controller: default widths, entry count, starvation limit
//                and the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int CACHE_DATA_W     = 16;
    localparam int CACHE_ADDR_W     = 10;
    localparam int CACHE_DEPTH      = 64;
    localparam int CACHE_STARVE_MAX = 4;

    // Starvation counter width; covers limits from 1 to 15.
    localparam int STARVE_W = 4;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } wr_state_e;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_write_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_write_ctrl_if
//  Description : Bundle of the two write requesters (CPU store path and
//                debug/program loader) plus the registered CACHE write port.
//                master : requester / store side (drives requests, sees
//                         grants and write-port outputs)
//                slave  : cache_write_ctrl (drives grants and write port)
//  Revision    : 1.0 - initial release
// ============================================================================
interface cache_write_ctrl_if
    import cache_pkg::*;
#(
    parameter int DATA_W = CACHE_DATA_W,
    parameter int ADDR_W = CACHE_ADDR_W
);

    logic              cpu_wr_req;
    logic [ADDR_W-1:0] cpu_wr_addr;
    logic [DATA_W-1:0] cpu_wr_data;
    logic              cpu_wr_gnt;

    logic              dbg_wr_req;
    logic [ADDR_W-1:0] dbg_wr_addr;
    logic [DATA_W-1:0] dbg_wr_data;
    logic              dbg_wr_gnt;

    logic              mem_write;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              init_done;
    logic              addr_err;

    modport master (
        output cpu_wr_req, cpu_wr_addr, cpu_wr_data,
        input  cpu_wr_gnt,
        output dbg_wr_req, dbg_wr_addr, dbg_wr_data,
        input  dbg_wr_gnt,
        input  mem_write, mem_waddr, mem_wdata, init_done, addr_err
    );

    modport slave (
        input  cpu_wr_req, cpu_wr_addr, cpu_wr_data,
        output cpu_wr_gnt,
        input  dbg_wr_req, dbg_wr_addr, dbg_wr_data,
        output dbg_wr_gnt,
        output mem_write, mem_waddr, mem_wdata, init_done, addr_err
    );

endinterface : cache_write_ctrl_if
`default_nettype wire

// File: rtl/cache_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cache_wr_arb
//  Description : Fixed-priority write arbiter with a loader starvation guard.
//                The CPU normally wins; once the loader has been refused
//                STARVE_MAX consecutive cycles it wins the next contest.
//  Ports       : clk, Reset      - clock, synchronous active-high reset
//                i_run           - arbitration enabled (RUN and not in reset)
//                i_cpu_req       - CPU store request
//                i_dbg_req       - loader request
//                o_cpu_gnt       - combinational CPU grant
//                o_dbg_gnt       - combinational loader grant
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_wr_arb
    import cache_pkg::*;
#(
    parameter int STARVE_MAX = CACHE_STARVE_MAX
) (
    input  wire  clk,
    input  wire  Reset,
    input  wire  i_run,
    input  wire  i_cpu_req,
    input  wire  i_dbg_req,
    output logic o_cpu_gnt,
    output logic o_dbg_gnt
);

    localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt_q;
    logic [STARVE_W-1:0] starve_cnt_d;
    logic                w_starved;

    always_comb begin
        w_starved    = (starve_cnt_q == C_STARVE_MAX);
        o_cpu_gnt    = 1'b0;
        o_dbg_gnt    = 1'b0;
        starve_cnt_d = starve_cnt_q;

        if (i_run) begin
            if (i_dbg_req && w_starved) begin
                o_dbg_gnt = 1'b1;
            end else if (i_cpu_req) begin
                o_cpu_gnt = 1'b1;
            end else if (i_dbg_req) begin
                o_dbg_gnt = 1'b1;
            end
        end

        // Counts consecutive refused loader cycles; any break in the
        // request or a loader grant restarts the count.
        if (!i_run || !i_dbg_req || o_dbg_gnt) begin
            starve_cnt_d = '0;
        end else if (!w_starved) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule : cache_wr_arb
`default_nettype wire

// File: rtl/cache_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cache_write_ctrl
//  Description : Owner of the single CACHE write port. After reset it
//                zero-fills all DEPTH entries, then arbitrates the port
//                between the CPU store path and the debug/program loader.
//                Write-port outputs are registered (grant -> write next edge).
//  Ports       : clk    - clock
//                Reset  - synchronous, active-high reset
//                bus    - cache_write_ctrl_if.slave: requests/grants from the
//                         CPU and loader, mem_write/mem_waddr/mem_wdata to the
//                         store, init_done and addr_err status
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_write_ctrl
    import cache_pkg::*;
#(
    parameter int DATA_W     = CACHE_DATA_W,
    parameter int ADDR_W     = CACHE_ADDR_W,
    parameter int DEPTH      = CACHE_DEPTH,
    parameter int STARVE_MAX = CACHE_STARVE_MAX
) (
    input  wire              clk,
    input  wire              Reset,
    cache_write_ctrl_if.slave bus
);

    localparam int                FILL_W    = $clog2(DEPTH);
    localparam logic [FILL_W-1:0] C_FILL_LAST = FILL_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] C_DEPTH_A   = ADDR_W'(DEPTH);

    wr_state_e         state_q,     state_d;
    logic [FILL_W-1:0] fill_cnt_q,  fill_cnt_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              init_done_q, init_done_d;
    logic              addr_err_q,  addr_err_d;

    logic              w_run;
    logic              w_cpu_gnt;
    logic              w_dbg_gnt;
    logic [ADDR_W-1:0] w_win_addr;
    logic [DATA_W-1:0] w_win_data;

    // Grants are held off during reset so a requester is never released
    // for a write that the reset is about to discard.
    assign w_run = (state_q == RUN) && !Reset;

    cache_wr_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk       (clk),
        .Reset     (Reset),
        .i_run     (w_run),
        .i_cpu_req (bus.cpu_wr_req),
        .i_dbg_req (bus.dbg_wr_req),
        .o_cpu_gnt (w_cpu_gnt),
        .o_dbg_gnt (w_dbg_gnt)
    );

    assign w_win_addr = w_dbg_gnt ? bus.dbg_wr_addr : bus.cpu_wr_addr;
    assign w_win_data = w_dbg_gnt ? bus.dbg_wr_data : bus.cpu_wr_data;

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        mem_write_d = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        init_done_d = init_done_q;
        addr_err_d  = 1'b0;

        case (state_q)
            INIT: begin
                mem_write_d = 1'b1;
                mem_waddr_d = ADDR_W'(fill_cnt_q);
                mem_wdata_d = '0;
                fill_cnt_d  = fill_cnt_q + FILL_W'(1);
                if (fill_cnt_q == C_FILL_LAST) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                if (w_cpu_gnt || w_dbg_gnt) begin
                    // Out-of-range writes are still granted (releasing the
                    // requester) but never reach the store.
                    if (w_win_addr >= C_DEPTH_A) begin
                        addr_err_d = 1'b1;
                    end else begin
                        mem_write_d = 1'b1;
                        mem_waddr_d = w_win_addr;
                        mem_wdata_d = w_win_data;
                    end
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= INIT;
            fill_cnt_q  <= '0;
            mem_write_q <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            init_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            mem_write_q <= mem_write_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            init_done_q <= init_done_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign bus.cpu_wr_gnt = w_cpu_gnt;
    assign bus.dbg_wr_gnt = w_dbg_gnt;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_waddr  = mem_waddr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.init_done  = init_done_q;
    assign bus.addr_err   = addr_err_q;

endmodule : cache_write_ctrl
`default_nettype wire
